// File: rtl/vga_rx_monitor_if.sv
// VGA link bundle: sync pulses plus 12-bit RGB as driven off-chip.
// The source side uses the master modport, the receive monitor the slave modport.
`timescale 1ns/1ps
interface vga_rx_monitor_if;
  logic        vga_hs;
  logic        vga_vs;
  logic [11:0] vga_rgb;

  modport master (output vga_hs, output vga_vs, output vga_rgb);
  modport slave  (input  vga_hs, input  vga_vs, input  vga_rgb);
endinterface

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive end of the looped-back VGA link. Recovers the beam
// position from HS/VS, checks line/frame timing, locks onto a clean raster and
// produces a 16-bit additive checksum of every complete locked frame.
// Optional feature: define VGA_RX_BLANK_CHECK_EN to treat non-zero RGB outside
// the active area as a timing error while checking or locked.
`timescale 1ns/1ps
module vga_rx_monitor #(
  parameter int H_ACTIVE = 1024,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int H_TOTAL  = 1344,
  parameter int V_ACTIVE = 768,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int V_TOTAL  = 806,
  parameter int SYNC_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  vga_rx_monitor_if.slave vga,
  output logic [10:0]   rx_x,
  output logic [9:0]    rx_y,
  output logic [11:0]   rx_rgb,
  output logic          rx_valid,
  output logic          locked,
  output logic          frame_done,
  output logic [15:0]   frame_checksum,
  output logic [7:0]    error_count
);

  // Raw level of a deasserted sync line; also the reset value of the sync pipeline
  // so that leaving reset never looks like a sync edge.
  localparam logic        IDLE_LVL = (SYNC_LOW != 0);
  localparam logic [10:0] H_LO     = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI     = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LO     = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_HI     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_TOT    = 12'(H_TOTAL);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state, state_next;
  logic        hs_s1, vs_s1, hs_s2, vs_s2;
  logic [11:0] rgb_s1;
  logic [10:0] h_cnt, h_pos;
  logic [9:0]  v_cnt, v_pos;
  logic        hs_seen;
  logic [15:0] acc;
  logic        hs_start, vs_start;
  logic        line_err, frame_err, sat_err, blank_err, any_err;
  logic        in_active, pix_valid;

  // Stage 1 captures the link; stage 2 keeps the previous sync levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1  <= IDLE_LVL;
      vs_s1  <= IDLE_LVL;
      hs_s2  <= IDLE_LVL;
      vs_s2  <= IDLE_LVL;
      rgb_s1 <= '0;
    end else begin
      hs_s1  <= vga.vga_hs;
      vs_s1  <= vga.vga_vs;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      rgb_s1 <= vga.vga_rgb;
    end
  end

  // Sync edges, beam position of the stage-1 pixel, error classification and next state.
  always_comb begin
    hs_start = (hs_s1 ^ IDLE_LVL) & ~(hs_s2 ^ IDLE_LVL);
    vs_start = (vs_s1 ^ IDLE_LVL) & ~(vs_s2 ^ IDLE_LVL);

    // Counters saturate rather than wrap so a dead link shows up as a stuck maximum.
    if (hs_start)              h_pos = '0;
    else if (h_cnt == 11'h7FF) h_pos = h_cnt;
    else                       h_pos = h_cnt + 11'd1;

    if (vs_start)              v_pos = '0;
    else if (!hs_start)        v_pos = v_cnt;
    else if (v_cnt == 10'h3FF) v_pos = v_cnt;
    else                       v_pos = v_cnt + 10'd1;

    // h_cnt still holds the last column of the previous line, so +1 is its length.
    line_err  = hs_start && hs_seen && (({1'b0, h_cnt} + 12'd1) != H_TOT);
    // A VS edge must coincide with an HS edge, which closes the last line of the frame.
    frame_err = vs_start && (!hs_start || (({1'b0, v_cnt} + 11'd1) != V_TOT));
    sat_err   = (h_pos == 11'h7FF) || (v_pos == 10'h3FF);
    in_active = (h_pos >= H_LO) && (h_pos < H_HI) && (v_pos >= V_LO) && (v_pos < V_HI);
`ifdef VGA_RX_BLANK_CHECK_EN
    blank_err = !in_active && (rgb_s1 != 12'h000);
`else
    blank_err = 1'b0;
`endif
    any_err = (state != SEARCH) && (line_err || frame_err || sat_err || blank_err);

    state_next = state;
    if (any_err) begin
      state_next = SEARCH;
    end else if (vs_start) begin
      case (state)
        SEARCH:  state_next = CHECK;
        CHECK:   state_next = LOCKED;
        default: state_next = state;
      endcase
    end
    pix_valid = (state_next == LOCKED) && in_active;
  end

  // Beam counters, lock FSM, error counter, checksum and registered pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SEARCH;
      h_cnt          <= '0;
      v_cnt          <= '0;
      hs_seen        <= 1'b0;
      acc            <= '0;
      rx_x           <= '0;
      rx_y           <= '0;
      rx_rgb         <= '0;
      rx_valid       <= 1'b0;
      locked         <= 1'b0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      error_count    <= '0;
    end else begin
      state  <= state_next;
      locked <= (state_next == LOCKED);
      h_cnt  <= h_pos;
      v_cnt  <= v_pos;

      // The first HS after losing lock closes a line of unknown length, so it is not judged.
      if (any_err)       hs_seen <= 1'b0;
      else if (hs_start) hs_seen <= 1'b1;

      if (any_err && (error_count != 8'hFF)) error_count <= error_count + 8'd1;

      frame_done <= 1'b0;
      if (!any_err && vs_start && (state == SEARCH)) begin
        acc <= '0;
      end else if (!any_err && vs_start && (state == LOCKED)) begin
        frame_checksum <= acc;
        frame_done     <= 1'b1;
        acc            <= '0;
      end else if (pix_valid) begin
        acc <= acc + {4'b0000, rgb_s1};
      end

      rx_valid <= pix_valid;
      if (pix_valid) begin
        rx_x   <= h_pos - H_LO;
        rx_y   <= v_pos - V_LO;
        rx_rgb <= rgb_s1;
      end
    end
  end

endmodule
